// File: rtl/dispatch_credit_ctrl_pkg.sv
// Shared types and default sizing for the dispatch stage, RS and ROB.
package dispatch_credit_ctrl_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned RS_DEPTH  = 16;

  typedef enum logic [1:0] {
    FU_ALU0 = 2'b00,
    FU_ALU1 = 2'b01,
    FU_MEM  = 2'b10
  } fu_sel_e;

endpackage

// File: rtl/dispatch_credit_ctrl_occ_counter.sv
// Up/down occupancy counter with clamp-at-zero and an underflow strobe.
module occ_counter #(
  parameter int unsigned DEPTH     = 16,
  // 1: the decrement is checked against the registered count only, and
  //    entries added this cycle are applied after the clamp (ROB retire).
  // 0: the decrement may consume entries added this cycle (RS issue).
  parameter bit          DEC_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [1:0]               inc,
  input  logic [1:0]               dec,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
);

  localparam int unsigned W = $clog2(DEPTH) + 1;
  typedef logic [W:0] ext_t;

  ext_t inc_x;
  ext_t dec_x;
  ext_t base;
  ext_t rem;
  ext_t nxt;
  logic uf;

  // Next occupancy: apply the net delta once, clamping at zero on underflow.
  always_comb begin
    inc_x     = ext_t'(inc);
    dec_x     = ext_t'(dec);
    base      = DEC_FIRST ? ext_t'(count) : ext_t'(count) + inc_x;
    uf        = dec_x > base;
    rem       = uf ? '0 : base - dec_x;
    nxt       = DEC_FIRST ? rem + inc_x : rem;
    underflow = uf & ~clear;
  end

  // Occupancy register; clear wins over any concurrent delta.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= W'(nxt);
    end
  end

endmodule

// File: rtl/dispatch_credit_ctrl.sv
// Dispatch credit controller: ROB index allocation, RS/ROB credit stall,
// ALU load balancing and memory-op routing for the 2-wide dispatch stage.
module dispatch_credit_ctrl #(
  parameter int unsigned ROB_DEPTH = dispatch_credit_ctrl_pkg::ROB_DEPTH,
  parameter int unsigned RS_DEPTH  = dispatch_credit_ctrl_pkg::RS_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    disp_valid,
  input  logic [1:0]                    disp_is_mem,
  input  logic [1:0]                    issue_free,
  input  logic [1:0]                    retire_cnt,
  input  logic                          flush,
  output logic                          stall,
  output logic [1:0]                    fire,
  output logic [$clog2(ROB_DEPTH)-1:0]  rob_idx_a,
  output logic [$clog2(ROB_DEPTH)-1:0]  rob_idx_b,
  output logic [1:0]                    fu_sel_a,
  output logic [1:0]                    fu_sel_b,
  output logic [$clog2(ROB_DEPTH)-1:0]  rob_head,
  output logic [$clog2(ROB_DEPTH):0]    rob_count,
  output logic [$clog2(RS_DEPTH):0]     rs_count,
  output logic                          err
);

  import dispatch_credit_ctrl_pkg::*;

  localparam int unsigned PW  = $clog2(ROB_DEPTH);
  localparam int unsigned RCW = PW + 1;
  localparam int unsigned SCW = $clog2(RS_DEPTH) + 1;

  typedef logic [RCW:0] rob_ext_t;
  typedef logic [SCW:0] rs_ext_t;

  logic [PW-1:0] rob_tail;
  logic          alu_rr;
  logic          illegal;
  logic [1:0]    valid_eff;
  logic [1:0]    need;
  logic [1:0]    fire_cnt;
  logic          alu_odd;
  logic          a_is_alu;
  logic          rob_uf;
  logic          rs_uf;
  fu_sel_e       sel_a;
  fu_sel_e       sel_b;

  // Credit check against registered counts; a pair is accepted whole or not at all.
  always_comb begin
    illegal   = (disp_valid == 2'b10);
    valid_eff = illegal ? 2'b00 : disp_valid;
    need      = {1'b0, valid_eff[0]} + {1'b0, valid_eff[1]};
    stall     = flush |
                ((need != 2'd0) &
                 (((rob_ext_t'(rob_count) + rob_ext_t'(need)) > rob_ext_t'(ROB_DEPTH)) |
                  ((rs_ext_t'(rs_count) + rs_ext_t'(need)) > rs_ext_t'(RS_DEPTH))));
    fire      = valid_eff & {2{~stall}};
    fire_cnt  = {1'b0, fire[0]} + {1'b0, fire[1]};
    alu_odd   = ^(fire & ~disp_is_mem);
  end

  // FU routing in slot order: mem ops to MEM, ALU ops alternate from alu_rr.
  always_comb begin
    sel_a    = FU_ALU0;
    sel_b    = FU_ALU0;
    a_is_alu = valid_eff[0] & ~disp_is_mem[0];
    if (valid_eff[0]) begin
      if (disp_is_mem[0]) sel_a = FU_MEM;
      else                sel_a = alu_rr ? FU_ALU1 : FU_ALU0;
    end
    if (valid_eff[1]) begin
      if (disp_is_mem[1])          sel_b = FU_MEM;
      else if (alu_rr ^ a_is_alu)  sel_b = FU_ALU1;
      else                         sel_b = FU_ALU0;
    end
  end

  assign fu_sel_a  = sel_a;
  assign fu_sel_b  = sel_b;
  assign rob_idx_a = rob_tail;
  assign rob_idx_b = rob_tail + PW'(1);

  // ROB pointers and ALU balance bit; flush rewinds the tail to the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rob_head <= '0;
      rob_tail <= '0;
      alu_rr   <= 1'b0;
    end else if (flush) begin
      rob_tail <= rob_head;
      alu_rr   <= 1'b0;
    end else begin
      rob_tail <= rob_tail + PW'(fire_cnt);
      rob_head <= rob_head + PW'(retire_cnt);
      if (alu_odd) alu_rr <= ~alu_rr;
    end
  end

  // Sticky error: counter underflow or the illegal slot-b-only pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (illegal | rob_uf | rs_uf) begin
      err <= 1'b1;
    end
  end

  occ_counter #(
    .DEPTH     (ROB_DEPTH),
    .DEC_FIRST (1'b1)
  ) u_rob_occ (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .inc       (fire_cnt),
    .dec       (retire_cnt),
    .count     (rob_count),
    .underflow (rob_uf)
  );

  occ_counter #(
    .DEPTH     (RS_DEPTH),
    .DEC_FIRST (1'b0)
  ) u_rs_occ (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .inc       (fire_cnt),
    .dec       (issue_free),
    .count     (rs_count),
    .underflow (rs_uf)
  );

endmodule
